// File: rtl/diila_trig_seq_if.sv
// diila_trig_seq_if: Wishbone slave bus bundle (data, address, byte selects, handshake, ack/err/rty)
interface diila_trig_seq_if;
  logic [31:0] wb_dat_i;
  logic [7:2]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/diila_trig_seq.sv
// diila_trig_seq: multi-stage masked-compare trigger sequencer; ports wb_clk_i/wb_rst_i, wb (WB slave), sig_i in, trig_o/armed_o/stage_o out
module diila_trig_seq #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  diila_trig_seq_if.slave wb,
  input  logic [31:0] sig_i,
  output logic        trig_o,
  output logic        armed_o,
  output logic [1:0]  stage_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] stage_q, stage_d, last_q, last_wr;
  logic [CNT_WIDTH-1:0] hit_q, hit_d, tmo_q, tmo_d;
  logic trig_q, trig_d, ack_q;
  logic [31:0] value_q [4];
  logic [31:0] mask_q [4];
  logic [CNT_WIDTH-1:0] count_q [4];
  logic [CNT_WIDTH-1:0] tlim_q [4];
  logic req, wr, in_map, arm, abort, match, fin, tmo_en;
  logic [5:0] adr, idx;
  logic [1:0] sel_s, fld;
  logic unused_sel;
  assign unused_sel = &wb.wb_sel_i;
  assign adr = wb.wb_adr_i;
  assign req = wb.wb_cyc_i & wb.wb_stb_i;
  assign wr = req & wb.wb_we_i;
  // stage registers occupy a 4-word block per stage starting at word 4
  assign idx = adr - 6'd4;
  assign sel_s = idx[3:2];
  assign fld = idx[1:0];
  assign in_map = (adr >= 6'd4) && (idx < 6'(4 * NUM_STAGES));
  assign arm = wr && adr == 6'd0 && wb.wb_dat_i[0];
  assign abort = wr && adr == 6'd0 && wb.wb_dat_i[1];
  assign last_wr = (wb.wb_dat_i >= 32'(NUM_STAGES)) ? 2'(NUM_STAGES - 1) : wb.wb_dat_i[1:0];
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign trig_o = trig_q;
  assign armed_o = state_q == RUN;
  assign stage_o = stage_q;
  always_comb begin
    wb.wb_dat_o = '0;
    if (adr == 6'd0)
      wb.wb_dat_o = {26'd0, stage_q, 2'd0, state_q == DONE, state_q == RUN};
    else if (adr == 6'd1)
      wb.wb_dat_o = {30'd0, last_q};
    else if (in_map)
      wb.wb_dat_o = fld == 2'd0 ? value_q[sel_s] :
                    fld == 2'd1 ? mask_q[sel_s] :
                    fld == 2'd2 ? 32'(count_q[sel_s]) : 32'(tlim_q[sel_s]);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      last_q <= 2'(NUM_STAGES - 1);
      for (int s = 0; s < 4; s++) begin
        value_q[s] <= '0;
        mask_q[s] <= '0;
        count_q[s] <= '0;
        tlim_q[s] <= '0;
      end
    end else begin
      // a held strobe sees ack toggle, so each ack marks exactly one cycle
      ack_q <= req & ~ack_q;
      if (wr && adr == 6'd1) last_q <= last_wr;
      if (wr && in_map && fld == 2'd0) value_q[sel_s] <= wb.wb_dat_i;
      if (wr && in_map && fld == 2'd1) mask_q[sel_s] <= wb.wb_dat_i;
      if (wr && in_map && fld == 2'd2) count_q[sel_s] <= wb.wb_dat_i[CNT_WIDTH-1:0];
      if (wr && in_map && fld == 2'd3) tlim_q[sel_s] <= wb.wb_dat_i[CNT_WIDTH-1:0];
    end
  end
  assign match = ((sig_i ^ value_q[stage_q]) & mask_q[stage_q]) == 32'd0;
  assign fin = hit_q == count_q[stage_q];
  assign tmo_en = stage_q != 2'd0 && tlim_q[stage_q] != '0;
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    hit_d = hit_q;
    tmo_d = tmo_q;
    trig_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      stage_d = '0;
      hit_d = '0;
      tmo_d = '0;
    end else if (arm) begin
      state_d = RUN;
      stage_d = '0;
      hit_d = '0;
      tmo_d = '0;
    end else if (state_q == RUN) begin
      if (match && fin && stage_q == last_q) begin
        state_d = DONE;
        trig_d = 1'b1;
      end else if (match && fin) begin
        stage_d = stage_q + 2'd1;
        hit_d = '0;
        tmo_d = '0;
      end else begin
        hit_d = match ? hit_q + 1'b1 : hit_q;
        // timeout only applies when the stage did not advance this cycle
        if (tmo_en && tmo_q == tlim_q[stage_q] - 1'b1) begin
          stage_d = '0;
          hit_d = '0;
          tmo_d = '0;
        end else if (tmo_en) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      stage_q <= '0;
      hit_q <= '0;
      tmo_q <= '0;
      trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      hit_q <= hit_d;
      tmo_q <= tmo_d;
      trig_q <= trig_d;
    end
  end
endmodule

// File: tb/tb_diila_trig_seq.sv
// tb_diila_trig_seq: table-driven register checks plus directed trigger sequences for diila_trig_seq
module tb_diila_trig_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] sig = '0;
  logic trig, armed;
  logic [1:0] stage;
  int total = 0;
  int passed = 0;
  diila_trig_seq_if wb();
  diila_trig_seq #(.NUM_STAGES(2), .CNT_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb.slave),
    .sig_i(sig), .trig_o(trig), .armed_o(armed), .stage_o(stage)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [5:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask
  task automatic step(input logic [31:0] s);
    sig = s;
    @(posedge clk);
    #1;
  endtask
  task automatic acc(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = 4'hF;
    @(posedge clk);
    #1;
    chk("ack", {31'd0, wb.wb_ack_o}, 32'd1);
    rd = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i = 1'b0;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    chk("ack_drop", {31'd0, wb.wb_ack_o}, 32'd0);
  endtask
  task automatic wr(input logic [5:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    acc(1'b1, adr, dat, d);
    idle();
  endtask
  task automatic rdchk(input string name, input logic [5:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    acc(1'b0, adr, 32'd0, d);
    chk(name, d, exp);
    idle();
  endtask
  task automatic arm();
    logic [31:0] d;
    acc(1'b1, 6'd0, 32'd1, d);
  endtask
  initial begin
    logic [31:0] d;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_trig", {31'd0, trig}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_stage", {30'd0, stage}, 32'd0);
    chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    chk("err_rty", {30'd0, wb.wb_err_o, wb.wb_rty_o}, 32'd0);
    tbl.push_back('{1'b0, 6'd0,  32'd0,         32'd0});
    tbl.push_back('{1'b0, 6'd1,  32'd0,         32'd1});
    tbl.push_back('{1'b0, 6'd4,  32'd0,         32'd0});
    tbl.push_back('{1'b0, 6'd9,  32'd0,         32'd0});
    tbl.push_back('{1'b1, 6'd4,  32'hDEADBEEF,  32'd0});
    tbl.push_back('{1'b0, 6'd4,  32'd0,         32'hDEADBEEF});
    tbl.push_back('{1'b1, 6'd5,  32'h0000FFFF,  32'd0});
    tbl.push_back('{1'b0, 6'd5,  32'd0,         32'h0000FFFF});
    tbl.push_back('{1'b1, 6'd6,  32'h12345678,  32'd0});
    tbl.push_back('{1'b0, 6'd6,  32'd0,         32'h00005678});
    tbl.push_back('{1'b1, 6'd11, 32'hABCD0007,  32'd0});
    tbl.push_back('{1'b0, 6'd11, 32'd0,         32'd7});
    tbl.push_back('{1'b1, 6'd1,  32'd5,         32'd0});
    tbl.push_back('{1'b0, 6'd1,  32'd0,         32'd1});
    tbl.push_back('{1'b1, 6'd1,  32'd0,         32'd0});
    tbl.push_back('{1'b0, 6'd1,  32'd0,         32'd0});
    tbl.push_back('{1'b1, 6'd12, 32'hFFFFFFFF,  32'd0});
    tbl.push_back('{1'b0, 6'd12, 32'd0,         32'd0});
    tbl.push_back('{1'b1, 6'h3F, 32'd1,         32'd0});
    tbl.push_back('{1'b0, 6'h3F, 32'd0,         32'd0});
    tbl.push_back('{1'b0, 6'd2,  32'd0,         32'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      acc(tbl[i].we, tbl[i].adr, tbl[i].dat, d);
      if (!tbl[i].we) chk($sformatf("reg[%0d]@0x%0h", i, tbl[i].adr), d, tbl[i].exp);
      idle();
    end
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    rdchk("rst_value0", 6'd4, 32'd0);
    rdchk("rst_count0", 6'd6, 32'd0);
    // always-match stage 0 as the final stage
    wr(6'd1, 32'd0);
    arm();
    chk("t1_armed", {31'd0, armed}, 32'd1);
    chk("t1_trig0", {31'd0, trig}, 32'd0);
    step(0);
    chk("t1_trig", {31'd0, trig}, 32'd1);
    chk("t1_armed_fall", {31'd0, armed}, 32'd0);
    step(0);
    chk("t1_trig_end", {31'd0, trig}, 32'd0);
    rdchk("t1_ctrl", 6'd0, 32'h2);
    // three non-consecutive matches needed
    wr(6'd4, 32'hA5);
    wr(6'd5, 32'hFF);
    wr(6'd6, 32'd2);
    arm();
    for (int i = 1; i <= 12; i++) begin
      step((i == 3 || i == 7 || i == 9) ? 32'hA5 : 32'h0);
      chk($sformatf("t2_trig_c%0d", i), {31'd0, trig}, {31'd0, i == 9});
    end
    // stage 0 = 0x1, stage 1 = 0x2 with timeout 5
    wr(6'd4, 32'h1);
    wr(6'd6, 32'd0);
    wr(6'd8, 32'h2);
    wr(6'd9, 32'hFF);
    wr(6'd11, 32'd5);
    wr(6'd1, 32'd1);
    arm();
    for (int i = 1; i <= 10; i++) begin
      step(i == 1 ? 32'h1 : i == 7 ? 32'h2 : 32'h0);
      chk($sformatf("t3a_trig_c%0d", i), {31'd0, trig}, 32'd0);
      chk($sformatf("t3a_stage_c%0d", i), {30'd0, stage}, (i >= 1 && i <= 5) ? 32'd1 : 32'd0);
    end
    chk("t3a_armed", {31'd0, armed}, 32'd1);
    arm();
    for (int i = 1; i <= 8; i++) begin
      step(i == 1 ? 32'h1 : i == 5 ? 32'h2 : 32'h0);
      chk($sformatf("t3b_trig_c%0d", i), {31'd0, trig}, {31'd0, i == 5});
    end
    // final match lands on the timeout expiry cycle
    arm();
    for (int i = 1; i <= 8; i++) begin
      step(i == 1 ? 32'h1 : i == 6 ? 32'h2 : 32'h0);
      chk($sformatf("t4_trig_c%0d", i), {31'd0, trig}, {31'd0, i == 6});
      chk($sformatf("t4_stage_c%0d", i), {30'd0, stage}, 32'd1);
    end
    rdchk("t4_ctrl", 6'd0, 32'h12);
    // abort plus arm together
    arm();
    step(0);
    step(0);
    chk("t5_armed_pre", {31'd0, armed}, 32'd1);
    acc(1'b1, 6'd0, 32'h3, d);
    chk("t5_armed_abort", {31'd0, armed}, 32'd0);
    idle();
    rdchk("t5_ctrl", 6'd0, 32'd0);
    arm();
    step(32'h1);
    chk("t5_stage1", {30'd0, stage}, 32'd1);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    chk("t5_rst_armed", {31'd0, armed}, 32'd0);
    chk("t5_rst_stage", {30'd0, stage}, 32'd0);
    chk("t5_rst_trig", {31'd0, trig}, 32'd0);
    chk("t5_rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    rdchk("t5_value0", 6'd4, 32'd0);
    rdchk("t5_mask0", 6'd5, 32'd0);
    rdchk("t5_value1", 6'd8, 32'd0);
    rdchk("t5_mask1", 6'd9, 32'd0);
    rdchk("t5_tmo1", 6'd11, 32'd0);
    rdchk("t5_last", 6'd1, 32'd1);
    rdchk("t5_ctrl", 6'd0, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
